// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed common-anode 7-segment scan driver
//
// Purpose: time-multiplexes four BCD digits onto a common-anode display.
// Each slot opens with a blank interval so the previous digit does not ghost.
// The inputs are snapshotted once per frame so a digit never tears mid-frame.
// The blink flag drives the decimal point of position 1.
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of position 0.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   digit1..digit4      - BCD digits, digit1 is the leftmost position
//   ptflag              - colon/blink flag (level sampled)
//   seg[6:0]            - segments a..g, active-low
//   dp                  - decimal point, active-low
//   an[3:0]             - anode enables, an[0] = digit1, active-low

module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic       ptflag,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            pt_q, pt_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic            wrap;
    logic            lzb_blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h40;
            4'd1:    r = 7'h79;
            4'd2:    r = 7'h24;
            4'd3:    r = 7'h30;
            4'd4:    r = 7'h19;
            4'd5:    r = 7'h12;
            4'd6:    r = 7'h02;
            4'd7:    r = 7'h78;
            4'd8:    r = 7'h00;
            4'd9:    r = 7'h10;
            default: r = 7'h3F;  // non-BCD shows a dash
        endcase
        return r;
    endfunction

    always_comb begin
        wrap  = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        // Snapshot on the edge that ends (idx=0, cnt=0). The next cycle is
        // always blank because BLANK_CYCLES >= 2, so the shadow is settled
        // before any digit is shown from it.
        dig_d = dig_q;
        pt_d  = pt_q;
        if (idx_q == 2'd0 && cnt_q == '0) begin
            dig_d = {digit4, digit3, digit2, digit1};
            pt_d  = ptflag;
        end

        state_d = state_q;
        if (wrap)
            state_d = ST_BLANK;
        else if (cnt_q == CW'(BLANK_CYCLES - 1))
            state_d = ST_SHOW;

`ifdef SEG7_LZB_EN
        lzb_blank = (idx_d == 2'd0) && (dig_q[0] == 4'd0);
`else
        lzb_blank = 1'b0;
`endif

        // Outputs are computed from the next-cycle state so that they are
        // registered yet aligned with the cnt value they belong to.
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW) begin
            if (!lzb_blank) begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = decode(dig_q[idx_d]);
            end
            dp_d = ~((idx_d == 2'd1) && pt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            dig_q   <= '0;
            pt_q    <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            pt_q    <= pt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
